// File: rtl/dcache_loadpipe_s0s1_if.sv
// -----------------------------------------------------------------------------
// dcache_loadpipe_s0s1_if
// Bundles the three handshakes of the load-pipe front end:
//   fromldu_req_*  : load request from the LDU (valid/ready + vaddr)
//   tagarray_rd_*  : tag-array read strobe/index and 1-cycle-latency data
//   tos2_*         : S1 result towards S2 (valid/ready + vaddr/hit info)
// Modports:
//   slave  : the load pipe (dcache_loadpipe_s0s1)
//   master : the surrounding LDU / tag array / S2 environment
// -----------------------------------------------------------------------------
interface dcache_loadpipe_s0s1_if #(
   parameter int VADDR_WIDTH = 39,
   parameter int IDX_HIGH    = 11,
   parameter int IDX_LOW     = 6,
   parameter int NUM_WAYS    = 4,
   parameter int TAG_WIDTH   = 27
);
   localparam int IDX_W  = IDX_HIGH - IDX_LOW + 1;
   localparam int DATA_W = NUM_WAYS * (TAG_WIDTH + 1);

   logic                   fromldu_req_valid;
   logic                   fromldu_req_ready;
   logic [VADDR_WIDTH-1:0] fromldu_req_vaddr;

   logic                   tagarray_rd_ready;
   logic                   tagarray_rd_en;
   logic [IDX_W-1:0]       tagarray_rd_idx;
   logic [DATA_W-1:0]      tagarray_rd_data;

   logic                   tos2_valid;
   logic                   tos2_ready;
   logic [VADDR_WIDTH-1:0] tos2_vaddr;
   logic                   tos2_hit;
   logic [NUM_WAYS-1:0]    tos2_hit_way;
   logic                   tos2_multihit;

   modport slave (
      input  fromldu_req_valid, fromldu_req_vaddr,
      output fromldu_req_ready,
      input  tagarray_rd_ready, tagarray_rd_data,
      output tagarray_rd_en, tagarray_rd_idx,
      input  tos2_ready,
      output tos2_valid, tos2_vaddr, tos2_hit, tos2_hit_way, tos2_multihit
   );

   modport master (
      output fromldu_req_valid, fromldu_req_vaddr,
      input  fromldu_req_ready,
      output tagarray_rd_ready, tagarray_rd_data,
      input  tagarray_rd_en, tagarray_rd_idx,
      output tos2_ready,
      input  tos2_valid, tos2_vaddr, tos2_hit, tos2_hit_way, tos2_multihit
   );
endinterface

// File: rtl/dcache_loadpipe_s0s1.sv
// -----------------------------------------------------------------------------
// dcache_loadpipe_s0s1
// Front two stages of the dcache load pipe.
//   S0 : accepts a load from the LDU and strobes the tag-array read.
//   S1 : compares the (1-cycle-later) tag-array output against the request
//        tag for every way and hands hit / one-hot hit-way to S2.
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   flush         : kills the S1 request and blocks S0 in the same cycle
//   bus (slave)   : LDU request, tag-array read, S2 result handshakes
//   perf_hit_cnt, perf_miss_cnt : saturating S1 hit/miss counters, present
//                   only when DCACHE_LOADPIPE_PERF_EN is defined
//
// S1 slot states:
//   state          | meaning
//   empty          | s1_valid_q=0, nothing in S1
//   live           | s1_valid_q=1, captured_q=0: compare uses tagarray_rd_data
//   captured       | s1_valid_q=1, captured_q=1: compare uses hold_q (stalled)
// -----------------------------------------------------------------------------
module dcache_loadpipe_s0s1 #(
   parameter int VADDR_WIDTH = 39,
   parameter int IDX_HIGH    = 11,
   parameter int IDX_LOW     = 6,
   parameter int NUM_WAYS    = 4,
   parameter int TAG_WIDTH   = 27
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   dcache_loadpipe_s0s1_if.slave bus
`ifdef DCACHE_LOADPIPE_PERF_EN
   ,
   output logic [31:0]           perf_hit_cnt,
   output logic [31:0]           perf_miss_cnt
`endif
);
   localparam int ENTRY_W = TAG_WIDTH + 1;
   localparam int DATA_W  = NUM_WAYS * ENTRY_W;

   logic                   s1_valid_q, s1_valid_d;
   logic                   captured_q, captured_d;
   logic [VADDR_WIDTH-1:0] s1_vaddr_q, s1_vaddr_d;
   logic [DATA_W-1:0]      hold_q, hold_d;

   logic                   tos2_valid_int;
   logic                   s1_fire;
   logic                   req_ready;
   logic                   s0_fire;

   logic [DATA_W-1:0]      tag_sel;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic [NUM_WAYS-1:0]    match;
   logic [NUM_WAYS-1:0]    hit_way_raw;
   logic                   hit_raw;
   logic                   multihit_raw;

   // handshakes
   always_comb begin
      tos2_valid_int = s1_valid_q && !flush;
      s1_fire        = tos2_valid_int && bus.tos2_ready;
      // S1 frees up either by being empty or by handing off this very cycle
      req_ready      = !reset && bus.tagarray_rd_ready && !flush &&
                       (!s1_valid_q || s1_fire);
      s0_fire        = bus.fromldu_req_valid && req_ready;
   end

   assign bus.fromldu_req_ready = req_ready;
   assign bus.tagarray_rd_en    = s0_fire;
   assign bus.tagarray_rd_idx   = bus.fromldu_req_vaddr[IDX_HIGH:IDX_LOW];

   // tag compare
   always_comb begin
      tag_sel = captured_q ? hold_q : bus.tagarray_rd_data;
      req_tag = s1_vaddr_q[VADDR_WIDTH-1:IDX_HIGH+1];
      match   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         match[w] = tag_sel[w*ENTRY_W + TAG_WIDTH] &&
                    (tag_sel[w*ENTRY_W +: TAG_WIDTH] == req_tag);
      end
      hit_raw      = |match;
      // two's-complement trick isolates the lowest set bit
      hit_way_raw  = match & (~match + NUM_WAYS'(1));
      // clearing the lowest set bit leaves something only if >1 bits were set
      multihit_raw = |(match & (match - NUM_WAYS'(1)));
   end

   assign bus.tos2_valid    = tos2_valid_int;
   assign bus.tos2_vaddr    = s1_vaddr_q;
   assign bus.tos2_hit      = tos2_valid_int && hit_raw;
   assign bus.tos2_hit_way  = tos2_valid_int ? hit_way_raw : '0;
   assign bus.tos2_multihit = tos2_valid_int && multihit_raw;

   // S1 slot next state
   always_comb begin
      s1_valid_d = s1_valid_q;
      captured_d = captured_q;
      s1_vaddr_d = s1_vaddr_q;
      hold_d     = hold_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         captured_d = 1'b0;
      end else if (s0_fire) begin
         // also covers the back-to-back case where S1 fires in this cycle
         s1_valid_d = 1'b1;
         s1_vaddr_d = bus.fromldu_req_vaddr;
         captured_d = 1'b0;
      end else if (s1_fire) begin
         s1_valid_d = 1'b0;
         captured_d = 1'b0;
      end else if (s1_valid_q && !captured_q) begin
         // the array output is only valid for one cycle; keep it for the stall
         hold_d     = bus.tagarray_rd_data;
         captured_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         captured_q <= 1'b0;
         s1_vaddr_q <= '0;
         hold_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         captured_q <= captured_d;
         s1_vaddr_q <= s1_vaddr_d;
         hold_q     <= hold_d;
      end
   end

`ifdef DCACHE_LOADPIPE_PERF_EN
   logic [31:0] perf_hit_q, perf_hit_d;
   logic [31:0] perf_miss_q, perf_miss_d;

   always_comb begin
      perf_hit_d  = perf_hit_q;
      perf_miss_d = perf_miss_q;
      if (s1_fire) begin
         if (hit_raw) begin
            if (perf_hit_q != 32'hFFFF_FFFF) perf_hit_d = perf_hit_q + 32'd1;
         end else begin
            if (perf_miss_q != 32'hFFFF_FFFF) perf_miss_d = perf_miss_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_hit_q  <= '0;
         perf_miss_q <= '0;
      end else begin
         perf_hit_q  <= perf_hit_d;
         perf_miss_q <= perf_miss_d;
      end
   end

   assign perf_hit_cnt  = perf_hit_q;
   assign perf_miss_cnt = perf_miss_q;
`endif

endmodule

// File: tb/tb_dcache_loadpipe_s0s1.sv
module tb_dcache_loadpipe_s0s1;
   localparam int VW  = 39;
   localparam int IH  = 11;
   localparam int IL  = 6;
   localparam int NW  = 4;
   localparam int TW  = 27;
   localparam int EW  = TW + 1;
   localparam int DW  = NW * EW;

   typedef struct packed {
      logic [VW-1:0] vaddr;
      logic          hit;
      logic [NW-1:0] hit_way;
      logic          multihit;
   } exp_t;

   logic clock;
   logic reset;
   logic flush;
   logic garbage;
   logic [DW-1:0] tag_mem [64];
   logic [127:0]  rnd;
   exp_t          sb_q [$];

   int checks;
   int failures;
   int handoffs;
   int valid_cycles;
   int rd_en_cnt;
   int last_accept;
   int exp_hits;
   int exp_misses;

   dcache_loadpipe_s0s1_if #(.VADDR_WIDTH(VW), .IDX_HIGH(IH), .IDX_LOW(IL),
                             .NUM_WAYS(NW), .TAG_WIDTH(TW)) bus ();

`ifdef DCACHE_LOADPIPE_PERF_EN
   logic [31:0] perf_hit_cnt;
   logic [31:0] perf_miss_cnt;
`endif

   dcache_loadpipe_s0s1 #(.VADDR_WIDTH(VW), .IDX_HIGH(IH), .IDX_LOW(IL),
                          .NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
`ifdef DCACHE_LOADPIPE_PERF_EN
      ,
      .perf_hit_cnt  (perf_hit_cnt),
      .perf_miss_cnt (perf_miss_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // tag array model: registered read, or random junk while garbage=1
   always @(posedge clock) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (garbage) bus.tagarray_rd_data <= rnd[DW-1:0];
      else if (bus.tagarray_rd_en) bus.tagarray_rd_data <= tag_mem[bus.tagarray_rd_idx];
   end

   function automatic exp_t model(input logic [VW-1:0] va);
      exp_t e;
      logic [DW-1:0] row;
      int cnt;
      row = tag_mem[va[IH:IL]];
      e.vaddr = va;
      e.hit = 1'b0;
      e.hit_way = '0;
      cnt = 0;
      for (int w = 0; w < NW; w++) begin
         if (row[w*EW + TW] && row[w*EW +: TW] == va[VW-1:IH+1]) begin
            if (cnt == 0) e.hit_way[w] = 1'b1;
            cnt++;
         end
      end
      e.hit = (cnt > 0);
      e.multihit = (cnt > 1);
      return e;
   endfunction

   task automatic set_way(input int idx, input int w, input logic v, input logic [TW-1:0] tag);
      tag_mem[idx][w*EW +: EW] = {v, tag};
   endtask

   function automatic logic [VW-1:0] mk_va(input logic [TW-1:0] tag, input logic [5:0] idx);
      return {tag, idx, 6'h00};
   endfunction

   // one clock: monitor at negedge, then return at posedge+1
   task automatic tick();
      exp_t e;
      exp_t got;
      @(negedge clock);
      last_accept = 0;
      if (reset || flush) begin
         sb_q.delete();
      end else begin
         if (bus.tos2_valid) valid_cycles++;
         if (bus.tagarray_rd_en) rd_en_cnt++;
         if (bus.tos2_valid && bus.tos2_ready) begin
            handoffs++;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got handoff vaddr %h, required no handoff", bus.tos2_vaddr);
            end else begin
               e = sb_q.pop_front();
               got = '{bus.tos2_vaddr, bus.tos2_hit, bus.tos2_hit_way, bus.tos2_multihit};
               if (got !== e) begin
                  failures++;
                  $display("FAIL sb_result: got %h, required %h", got, e);
               end
               if (e.hit) exp_hits++; else exp_misses++;
            end
         end
         if (bus.fromldu_req_valid && bus.fromldu_req_ready) begin
            last_accept = 1;
            sb_q.push_back(model(bus.fromldu_req_vaddr));
            checks++;
            if (bus.tagarray_rd_en !== 1'b1 || bus.tagarray_rd_idx !== bus.fromldu_req_vaddr[IH:IL]) begin
               failures++;
               $display("FAIL rd_strobe: got en=%b idx=%h, required en=1 idx=%h",
                        bus.tagarray_rd_en, bus.tagarray_rd_idx, bus.fromldu_req_vaddr[IH:IL]);
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (bus.fromldu_req_ready !== 1'b0 || bus.tos2_valid !== 1'b0 || bus.tagarray_rd_en !== 1'b0 ||
          bus.tos2_hit !== 1'b0 || bus.tos2_hit_way !== 4'b0000 || bus.tos2_multihit !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got ready=%b valid=%b en=%b hit=%b way=%b multi=%b, required all 0",
                  bus.fromldu_req_ready, bus.tos2_valid, bus.tagarray_rd_en, bus.tos2_hit,
                  bus.tos2_hit_way, bus.tos2_multihit);
      end
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.fromldu_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b, required 1", bus.fromldu_req_ready);
      end
   endtask

   task automatic test_single_hit();
      logic [VW-1:0] va;
      set_way(6'h2A, 2, 1'b1, 27'h1234567);
      va = mk_va(27'h1234567, 6'h2A);
      bus.tos2_ready = 1'b1;
      bus.fromldu_req_vaddr = va;
      bus.fromldu_req_valid = 1'b1;
      tick();
      bus.fromldu_req_valid = 1'b0;
      checks++;
      if (last_accept != 1) begin
         failures++;
         $display("FAIL hit_accept: got accept=%0d, required 1", last_accept);
      end
      checks++;
      if (bus.tos2_valid !== 1'b1 || bus.tos2_hit !== 1'b1 || bus.tos2_hit_way !== 4'b0100 ||
          bus.tos2_multihit !== 1'b0) begin
         failures++;
         $display("FAIL single_hit: got v=%b hit=%b way=%b multi=%b, required v=1 hit=1 way=0100 multi=0",
                  bus.tos2_valid, bus.tos2_hit, bus.tos2_hit_way, bus.tos2_multihit);
      end
      tick();
   endtask

   task automatic test_miss_invalid();
      set_way(6'h15, 0, 1'b0, 27'h0ABCDEF);
      bus.fromldu_req_vaddr = mk_va(27'h0ABCDEF, 6'h15);
      bus.fromldu_req_valid = 1'b1;
      tick();
      bus.fromldu_req_valid = 1'b0;
      checks++;
      if (bus.tos2_valid !== 1'b1 || bus.tos2_hit !== 1'b0 || bus.tos2_hit_way !== 4'b0000) begin
         failures++;
         $display("FAIL miss_invalid: got v=%b hit=%b way=%b, required v=1 hit=0 way=0000",
                  bus.tos2_valid, bus.tos2_hit, bus.tos2_hit_way);
      end
      tick();
   endtask

   task automatic test_backpressure();
      set_way(6'h10, 1, 1'b1, 27'h5555AAA);
      bus.tos2_ready = 1'b0;
      bus.fromldu_req_vaddr = mk_va(27'h5555AAA, 6'h10);
      bus.fromldu_req_valid = 1'b1;
      tick();
      bus.fromldu_req_valid = 1'b0;
      handoffs = 0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.tos2_valid !== 1'b1 || bus.tos2_hit_way !== 4'b0010 || bus.fromldu_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_stable[%0d]: got v=%b way=%b ready=%b, required v=1 way=0010 ready=0",
                     k, bus.tos2_valid, bus.tos2_hit_way, bus.fromldu_req_ready);
         end
         if (k == 1) garbage = 1'b1;
         tick();
      end
      bus.tos2_ready = 1'b1;
      tick();
      garbage = 1'b0;
      tick();
      checks++;
      if (handoffs != 1 || bus.tos2_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_handoff: got handoffs=%0d valid=%b, required 1 and 0", handoffs, bus.tos2_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] tag;
      handoffs = 0;
      valid_cycles = 0;
      rd_en_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tag = TW'($urandom());
         if (i != 5) set_way(6'h20 + i, i % 4, 1'b1, tag);
         bus.fromldu_req_vaddr = mk_va(tag, 6'(6'h20 + i));
         bus.fromldu_req_valid = 1'b1;
         tick();
         checks++;
         if (last_accept != 1) begin
            failures++;
            $display("FAIL stream_accept[%0d]: got %0d, required 1", i, last_accept);
         end
      end
      bus.fromldu_req_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (rd_en_cnt != 8 || handoffs != 8 || valid_cycles != 8) begin
         failures++;
         $display("FAIL stream_counts: got rd_en=%0d handoffs=%0d valid=%0d, required 8 8 8",
                  rd_en_cnt, handoffs, valid_cycles);
      end
   endtask

   task automatic test_flush_busy();
      set_way(6'h07, 3, 1'b1, 27'h0000077);
      bus.tos2_ready = 1'b0;
      bus.fromldu_req_vaddr = mk_va(27'h0000077, 6'h07);
      bus.fromldu_req_valid = 1'b1;
      tick();
      bus.fromldu_req_valid = 1'b0;
      tick();
      flush = 1'b1;
      bus.fromldu_req_valid = 1'b1;
      bus.fromldu_req_vaddr = mk_va(27'h0000078, 6'h08);
      #1;
      checks++;
      if (bus.tos2_valid !== 1'b0 || bus.fromldu_req_ready !== 1'b0 || bus.tagarray_rd_en !== 1'b0) begin
         failures++;
         $display("FAIL flush_cycle: got v=%b ready=%b en=%b, required 0 0 0",
                  bus.tos2_valid, bus.fromldu_req_ready, bus.tagarray_rd_en);
      end
      tick();
      flush = 1'b0;
      bus.fromldu_req_valid = 1'b0;
      bus.tos2_ready = 1'b1;
      #1;
      checks++;
      if (bus.tos2_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_after: got v=%b, required 0", bus.tos2_valid);
      end
      bus.tagarray_rd_ready = 1'b0;
      bus.fromldu_req_valid = 1'b1;
      #1;
      checks++;
      if (bus.fromldu_req_ready !== 1'b0 || bus.tagarray_rd_en !== 1'b0) begin
         failures++;
         $display("FAIL array_busy: got ready=%b en=%b, required 0 0", bus.fromldu_req_ready, bus.tagarray_rd_en);
      end
      tick();
      bus.fromldu_req_valid = 1'b0;
      bus.tagarray_rd_ready = 1'b1;
      tick();
   endtask

   task automatic test_multihit();
      set_way(6'h33, 0, 1'b1, 27'h0000001);
      set_way(6'h33, 1, 1'b1, 27'h3C3C3C3);
      set_way(6'h33, 2, 1'b0, 27'h3C3C3C3);
      set_way(6'h33, 3, 1'b1, 27'h3C3C3C3);
      bus.tos2_ready = 1'b1;
      bus.fromldu_req_vaddr = mk_va(27'h3C3C3C3, 6'h33);
      bus.fromldu_req_valid = 1'b1;
      tick();
      bus.fromldu_req_valid = 1'b0;
      checks++;
      if (bus.tos2_hit_way !== 4'b0010 || bus.tos2_multihit !== 1'b1 || bus.tos2_hit !== 1'b1) begin
         failures++;
         $display("FAIL multihit: got hit=%b way=%b multi=%b, required hit=1 way=0010 multi=1",
                  bus.tos2_hit, bus.tos2_hit_way, bus.tos2_multihit);
      end
      tick();
   endtask

   task automatic test_reset_mid();
`ifdef DCACHE_LOADPIPE_PERF_EN
      checks++;
      if (perf_hit_cnt !== 32'(exp_hits) || perf_miss_cnt !== 32'(exp_misses)) begin
         failures++;
         $display("FAIL perf_counts: got hit=%0d miss=%0d, required %0d %0d",
                  perf_hit_cnt, perf_miss_cnt, exp_hits, exp_misses);
      end
`endif
      set_way(6'h05, 0, 1'b1, 27'h0111111);
      bus.tos2_ready = 1'b0;
      bus.fromldu_req_vaddr = mk_va(27'h0111111, 6'h05);
      bus.fromldu_req_valid = 1'b1;
      tick();
      bus.fromldu_req_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (bus.tos2_valid !== 1'b0 || bus.fromldu_req_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: got v=%b ready=%b, required 0 0", bus.tos2_valid, bus.fromldu_req_ready);
      end
`ifdef DCACHE_LOADPIPE_PERF_EN
      checks++;
      if (perf_hit_cnt !== 32'd0 || perf_miss_cnt !== 32'd0) begin
         failures++;
         $display("FAIL perf_reset: got hit=%0d miss=%0d, required 0 0", perf_hit_cnt, perf_miss_cnt);
      end
`endif
      tick();
      reset = 1'b0;
      bus.tos2_ready = 1'b1;
      handoffs = 0;
      tick();
      tick();
      checks++;
      if (bus.tos2_valid !== 1'b0 || handoffs != 0) begin
         failures++;
         $display("FAIL reset_drop: got v=%b handoffs=%0d, required 0 0", bus.tos2_valid, handoffs);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      handoffs = 0;
      valid_cycles = 0;
      rd_en_cnt = 0;
      last_accept = 0;
      exp_hits = 0;
      exp_misses = 0;
      garbage = 1'b0;
      flush = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 64; i++) tag_mem[i] = '0;
      bus.fromldu_req_valid = 1'b0;
      bus.fromldu_req_vaddr = '0;
      bus.tagarray_rd_ready = 1'b1;
      bus.tagarray_rd_data = '0;
      bus.tos2_ready = 1'b1;
      test_reset();
      test_single_hit();
      test_miss_invalid();
      test_backpressure();
      test_back_to_back();
      test_flush_busy();
      test_multihit();
      test_reset_mid();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dcache_loadpipe_s0s1.md
Name: dcache_loadpipe_s0s1

Overview:
- Two-stage front of the dcache load pipe, generalised to NUM_WAYS ways and parametrised index/tag fields.
- S0 accepts a load request from the LDU and issues the tag-array read. S1 receives the 1-cycle-latency tag-array output and performs the per-way tag compare.
- S1 presents hit / one-hot hit-way to S2 under a valid/ready handshake. Full backpressure and flush are supported.

Parameters:
- VADDR_WIDTH, 39, virtual address width.
- IDX_HIGH, 11, MSB of set index in vaddr.
- IDX_LOW, 6, LSB of set index in vaddr (line offset below).
- NUM_WAYS, 4, associativity; must be >= 1.
- TAG_WIDTH, 27, tag width; must equal VADDR_WIDTH-IDX_HIGH-1.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kill all in-flight requests.
- fromldu_req_valid  in  1  load request valid.
- fromldu_req_ready  out  1  request accepted when valid&&ready.
- fromldu_req_vaddr  in  VADDR_WIDTH  load virtual address.
- tagarray_rd_ready  in  1  tag array free this cycle (0 while a refill is writing).
- tagarray_rd_en  out  1  tag array read strobe.
- tagarray_rd_idx  out  IDX_HIGH-IDX_LOW+1  set index.
- tagarray_rd_data  in  NUM_WAYS*(TAG_WIDTH+1)  per way {valid, tag}, way w at bits [(w+1)*(TAG_WIDTH+1)-1 : w*(TAG_WIDTH+1)], valid at MSB; valid one cycle after rd_en.
- tos2_valid  out  1  S1 result valid.
- tos2_ready  in  1  S2 can accept.
- tos2_vaddr  out  VADDR_WIDTH  vaddr of S1 request.
- tos2_hit  out  1  any way matched.
- tos2_hit_way  out  NUM_WAYS  one-hot matching way (lowest index on multi-match).
- tos2_multihit  out  1  more than one way matched (error indication).

Behaviour:
- Reset (async, active-high): s1_valid=0, capture flag=0, hold regs=0. All outputs are 0 except fromldu_req_ready.
- fromldu_req_ready is combinational: tagarray_rd_ready && !flush && (!s1_valid || (tos2_valid && tos2_ready)). It is also 0 while reset is asserted.
- S0 fire = fromldu_req_valid && fromldu_req_ready.
- tagarray_rd_en = S0 fire only; tagarray_rd_idx = fromldu_req_vaddr[IDX_HIGH:IDX_LOW], unconditionally.
- On S0 fire: s1_valid<=1, s1_vaddr<=fromldu_req_vaddr, captured<=0.
- On S1 fire (tos2_valid && tos2_ready) without an S0 fire in the same cycle: s1_valid<=0.
- Simultaneous S1 fire and S0 fire: back-to-back, so s1 reloads with the new request. Throughput is 1/cycle.
- Tag capture:
  - The first cycle after S0 fire, S1 compares against live tagarray_rd_data.
  - If S1 does not fire that cycle, tagarray_rd_data is registered into the hold reg and captured<=1.
  - While captured=1, the compare uses the hold reg. A stall of any length never re-reads the array.
- Compare per way w: match[w] = valid_w && (tag_w == s1_vaddr[VADDR_WIDTH-1:IDX_HIGH+1]).
  - tos2_hit = |match.
  - tos2_hit_way = lowest set bit of match; all zero on miss.
  - tos2_multihit = popcount(match) > 1.
- tos2_valid = s1_valid && !flush. tos2_vaddr = s1_vaddr.
- tos2_hit, tos2_hit_way and tos2_multihit are forced to 0 when tos2_valid=0.
- Flush takes priority over everything. s1_valid<=0 and captured<=0 next cycle. No S0 accept in the flush cycle, and no tos2_valid in the flush cycle.
- tagarray_rd_ready=0 blocks S0 only. A stalled S1 is unaffected.
- Reset mid-operation drops any request immediately with no response.
- Latency: accept at cycle N → tos2_valid at N+1 if no flush.

Optional Feature:
- Macro DCACHE_LOADPIPE_PERF_EN.
- When defined:
  - Adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0], each a saturating counter reset to 0.
  - Each increments once per S1 fire with tos2_hit=1 or 0 respectively. A request stalled for several cycles counts once.
  - Counters hold at 32'hFFFFFFFF.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single hit:
  - Stimulus: way2 = {1, tag 0x1234567}; vaddr = {0x1234567, idx 0x2A, 0x00}; tos2_ready=1.
  - Response: rd_en=1 with idx 0x2A at N; at N+1 tos2_valid=1, hit=1, hit_way=4'b0100, multihit=0.
- Miss and invalid way:
  - Stimulus: matching tag present but its valid=0.
  - Response: hit=0, hit_way=0.
- Backpressure:
  - Stimulus: tos2_ready=0 for 5 cycles after a hit request; tagarray_rd_data is changed to garbage on cycle 2.
  - Response: outputs remain stable (hit_way unchanged); fromldu_req_ready=0; tos2_valid stays 1; one handoff when ready rises.
- Back-to-back streaming:
  - Stimulus: 8 consecutive requests with tos2_ready=1 and tagarray_rd_ready=1.
  - Response: 8 rd_en pulses, 8 consecutive tos2_valid cycles, in order.
- Flush and array busy:
  - Stimulus: flush while S1 is stalled.
  - Response: tos2_valid=0 that cycle and after; fromldu_req_ready=0 during flush.
  - Stimulus: tagarray_rd_ready=0.
  - Response: fromldu_req_ready=0 and rd_en=0.
- Multi-hit and reset:
  - Stimulus: ways 1 and 3 match.
  - Response: hit_way=4'b0010, multihit=1.
  - Stimulus: assert reset mid-stall.
  - Response: tos2_valid drops asynchronously; perf counters (if enabled) read 0.
